// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector bank: channel edge modes and
// the filter counter width helper.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // Width of a counter that must reach filter-1; at least one bit so the
  // counter register always exists, even when no filtering is requested.
  function automatic int cnt_width(input int filter);
    return (filter <= 2) ? 1 : $clog2(filter);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel of the bank: glitch filter on the raw level, edge pulse
// generation under the channel's mode, and the sticky edge-seen flag.
module edge_channel
  import edge_pkg::*;
#(
  parameter int FILTER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       armed,
  input  logic       x,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       level,
  output logic       pulse,
  output logic       sticky
);

  localparam int CW = cnt_width(FILTER);
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          pulse_next;

  // Before arming, the level is copied straight from the input so a line
  // already active at reset release is not mistaken for an edge. Once
  // armed, a differing input must persist until the counter reaches LAST.
  always_comb begin
    level_next = level;
    cnt_next   = '0;
    pulse_next = 1'b0;
    if (!armed) begin
      level_next = x;
    end else if (x != level) begin
      if (cnt == LAST) begin
        level_next = x;
        case (edge_mode_e'(mode))
          MODE_RISE: pulse_next = x;
          MODE_FALL: pulse_next = ~x;
          MODE_BOTH: pulse_next = 1'b1;
          default:   pulse_next = 1'b0;
        endcase
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // Channel state; sticky holds across the arming edge and a new pulse
  // wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      level <= level_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      if (armed) begin
        sticky <= (sticky & ~clear) | pulse_next;
      end
    end
  end

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: N_CH independent filtered channels sharing
// an arming bit, with an interrupt combining the enabled sticky flags.
module edge_detector_bank
  import edge_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int FILTER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   x,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clear,
  input  logic [N_CH-1:0]   irq_en,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   sticky,
  output logic              irq
);

  logic armed;

  // Armed is set on the first edge after reset release and stays set,
  // marking that edge as the level-load edge for every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_channel #(
      .FILTER(FILTER)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .armed (armed),
      .x     (x[i]),
      .mode  (mode[2*i +: 2]),
      .clear (clear[i]),
      .level (level[i]),
      .pulse (pulse[i]),
      .sticky(sticky[i])
    );
  end

  assign irq = |(sticky & irq_en);

endmodule

// File: tb/tb_edge_detector_bank.sv
// Scoreboard bench for edge_detector_bank with FILTER=3: directed steps
// push hand-computed expectations, a monitor compares after each edge.
module tb_edge_detector_bank;

  localparam int N_CH   = 8;
  localparam int FILTER = 3;

  typedef struct {
    string      name;
    logic [7:0] level;
    logic [7:0] pulse;
    logic [7:0] sticky;
    logic       irq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   x;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   irq_en;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   pulse;
  logic [N_CH-1:0]   sticky;
  logic              irq;

  logic              rstV;
  logic [2*N_CH-1:0] modeV;
  logic [N_CH-1:0]   irqEnV;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  edge_detector_bank #(
    .N_CH  (N_CH),
    .FILTER(FILTER)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .mode  (mode),
    .clear (clear),
    .irq_en(irq_en),
    .level (level),
    .pulse (pulse),
    .sticky(sticky),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Compare the DUT outputs against one expectation.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (level !== e.level || pulse !== e.pulse || sticky !== e.sticky || irq !== e.irq) begin
      errors++;
      $display("[TB] FAIL %s: got level=%h pulse=%h sticky=%h irq=%b, want level=%h pulse=%h sticky=%h irq=%b",
               e.name, level, pulse, sticky, irq, e.level, e.pulse, e.sticky, e.irq);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic applyStimulus(input string name, input logic [7:0] xv, input logic [7:0] clr,
                               input logic [7:0] eLevel, input logic [7:0] ePulse,
                               input logic [7:0] eSticky, input logic eIrq);
    exp_t e;
    @(negedge clk);
    rst    = rstV;
    x      = xv;
    clear  = clr;
    mode   = modeV;
    irq_en = irqEnV;
    e.name   = name;
    e.level  = eLevel;
    e.pulse  = ePulse;
    e.sticky = eSticky;
    e.irq    = eIrq;
    sbQ.push_back(e);
  endtask

  // Hold x for a number of cycles; the change is accepted on the third edge.
  task automatic runPhase(input string name, input logic [7:0] xv, input int cycles,
                          input logic [7:0] lvlOld, input logic [7:0] lvlNew,
                          input logic [7:0] pulseAt, input logic [7:0] sOld,
                          input logic [7:0] sNew, input logic iOld, input logic iNew);
    for (int k = 1; k <= cycles; k++) begin
      if (k < 3)       applyStimulus(name, xv, 8'h00, lvlOld, 8'h00, sOld, iOld);
      else if (k == 3) applyStimulus(name, xv, 8'h00, lvlNew, pulseAt, sNew, iNew);
      else             applyStimulus(name, xv, 8'h00, lvlNew, 8'h00, sNew, iNew);
    end
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    exp_t z;
    z.level = 8'h00; z.pulse = 8'h00; z.sticky = 8'h00; z.irq = 1'b0;

    rst = 1'b0; x = 8'hFF; mode = 16'hFFFF; clear = 8'h00; irq_en = 8'hFF;
    rstV = 1'b0; modeV = 16'hFFFF; irqEnV = 8'hFF;
    #1 rst = 1'b1;
    #2;
    z.name = "reset_state";
    checkOutput(z);

    // Lines already high at release: loaded, no edges.
    applyStimulus("arm_load", 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("arm_hold", 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);

    // Re-arm with all lines low, ch0 rising, ch1 both.
    rstV = 1'b1;
    applyStimulus("rst_hold", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    rstV = 1'b0; modeV = 16'h000D; irqEnV = 8'h01;
    applyStimulus("rearm", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    runPhase("rise0", 8'h01, 4, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1);
    runPhase("fall0_risemode", 8'h00, 3, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1);

    // Two-edge glitch is discarded and the count restarts.
    applyStimulus("glitch0", 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    applyStimulus("glitch0", 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    applyStimulus("glitch0_end", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    runPhase("rise0_after_glitch", 8'h01, 4, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b1);
    runPhase("fall0_again", 8'h00, 3, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1);

    // Clear coinciding with a new pulse: set wins; then clear alone.
    applyStimulus("rise0_c1", 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    applyStimulus("rise0_c2", 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    applyStimulus("set_wins", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1);
    applyStimulus("clear0", 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
    applyStimulus("clear_idle", 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);

    // ch1 in both mode, irq not enabled for it.
    runPhase("ch1_rise_both", 8'h03, 6, 8'h01, 8'h03, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);
    runPhase("ch1_fall_both", 8'h01, 6, 8'h03, 8'h01, 8'h02, 8'h02, 8'h02, 1'b0, 1'b0);

    // ch1 in falling mode.
    modeV = 16'h0009;
    applyStimulus("clr1", 8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 1'b0);
    runPhase("ch1_rise_fallmode", 8'h03, 6, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    runPhase("ch1_fall_fallmode", 8'h01, 6, 8'h03, 8'h01, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);

    // ch1 off.
    modeV = 16'h0001;
    applyStimulus("clr1b", 8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 1'b0);
    runPhase("ch1_rise_off", 8'h03, 6, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    runPhase("ch1_fall_off", 8'h01, 6, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // ch2 rising with irq, then start a falling count and reset mid-filter.
    modeV = 16'h0011; irqEnV = 8'h04;
    runPhase("ch2_rise", 8'h05, 4, 8'h01, 8'h05, 8'h04, 8'h00, 8'h04, 1'b0, 1'b1);
    applyStimulus("ch2_cnt1", 8'h01, 8'h00, 8'h05, 8'h00, 8'h04, 1'b1);
    @(posedge clk);
    #2;
    rstV = 1'b1;
    rst  = 1'b1;
    #1;
    z.name = "async_rst";
    checkOutput(z);
    rstV = 1'b0;
    applyStimulus("rst_release", 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("post_rst_hold", 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
